// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, buffers fetched words in a small FIFO for decode.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
//
// state   | meaning
// --------+------------------------------------------------------
// S_FETCH | PC in range, capturing words into the fetch buffer
// S_END   | PC past the last legal word; buffer drains, no capture
// S_FAULT | misaligned redirect seen; fetch stopped until reset
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          MEM_BYTES  = 96,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    output logic        done,
    output logic        fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_END, S_FAULT} state_t;

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

    state_t      state;
    logic [63:0] pc;
    logic [63:0] pc_inc;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [31:0] buf_instr [FIFO_DEPTH];
    logic [63:0] buf_pc    [FIFO_DEPTH];
    logic        empty;
    logic        full;
    logic        deq;
    logic        redir;
    logic        push;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign deq    = !empty && id_ready;
    assign redir  = redirect_valid && (state != S_FAULT);
    assign push   = (state == S_FETCH) && (!full || deq) && !redir;
    assign pc_inc = pc + 64'd4;

    assign imem_addr = pc;
    assign if_valid  = !empty;
    assign if_instr  = buf_instr[rd_ptr[AW-1:0]];
    assign if_pc     = buf_pc[rd_ptr[AW-1:0]];
    assign done      = (state == S_END) && empty;
    assign fault     = (state == S_FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (redir) begin
            // Flush drops everything, including an entry decode is taking this edge.
            rd_ptr <= wr_ptr;
            if (redirect_pc[1:0] != 2'b00) begin
                state <= S_FAULT;
            end else begin
                pc    <= redirect_pc;
                state <= (redirect_pc > LAST_PC) ? S_END : S_FETCH;
            end
        end else begin
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                buf_instr[wr_ptr[AW-1:0]] <= imem_rdata;
                buf_pc[wr_ptr[AW-1:0]]    <= pc;
                wr_ptr <= wr_ptr + 1'b1;
                pc     <= pc_inc;
                if (pc_inc > LAST_PC) begin
                    state <= S_END;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [32:0] flushed_sum;

    assign flushed_sum = {1'b0, perf_flushed} + 33'(count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redir) begin
                perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
            end
            if ((state == S_FETCH) && full && !deq && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
